// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement add/subtract unit: one CHUNK-bit adder is reused
// LSB chunk first across a WIDTH-bit operand, with valid/ready on both sides.
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic             sat_reg;
  logic [CW-1:0]    k;

  logic [WIDTH-1:0] b_eff;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] raw_next;
  logic [WIDTH-1:0] final_result;
  logic             final_ovf;
  logic             a_msb;
  logic             b_msb;

  assign b_eff    = sub ? ~b : b;
  assign in_ready = (state == IDLE);
  assign a_msb    = a_reg[WIDTH-1];
  assign b_msb    = b_reg[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (k == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand chunk k feeds the shared CHUNK+1 bit adder; carry is the only inter-chunk state.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (k == CW'(i)) begin
        a_chunk = a_reg[i*CHUNK +: CHUNK];
        b_chunk = b_reg[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
  end

  // The last chunk's sum is merged here so overflow and saturation see the full raw result.
  always_comb begin
    raw_next = result;
    for (int i = 0; i < N; i++) begin
      if (k == CW'(i)) begin
        raw_next[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      end
    end
    final_ovf = (a_msb == b_msb) && (raw_next[WIDTH-1] != a_msb);
    if (sat_reg && final_ovf) begin
      final_result = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      final_result = raw_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      sat_reg   <= 1'b0;
      k         <= '0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b_eff;
            carry   <= sub;
            sat_reg <= sat;
            k       <= '0;
          end
        end
        RUN: begin
          carry  <= chunk_sum[CHUNK];
          result <= raw_next;
          k      <= k + 1'b1;
          if (k == LAST) begin
            result    <= final_result;
            cout      <= chunk_sum[CHUNK];
            ovf       <= final_ovf;
            zero      <= (final_result == '0);
            neg       <= final_result[WIDTH-1];
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq: three instances (32/8, 16/16, 16/4) driven with
// directed and random operations, checked against an arithmetic reference model.
module tb_addsub_seq;

  localparam int P = 10;

  logic clk = 1'b0;
  always #(P/2) clk = ~clk;

  logic        rst_n;
  logic        in_valid_s [3];
  logic        in_ready_s [3];
  logic        sub_s      [3];
  logic        sat_s      [3];
  logic        out_valid_s[3];
  logic        out_ready_s[3];
  logic        cout_s     [3];
  logic        ovf_s      [3];
  logic        zero_s     [3];
  logic        neg_s      [3];
  logic [31:0] a_s        [3];
  logic [31:0] b_s        [3];
  logic [31:0] res_s      [3];
  logic [15:0] res_p;
  logic [15:0] res_q;

  assign res_s[1] = {16'h0, res_p};
  assign res_s[2] = {16'h0, res_q};

  int rdy_mode[3];
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [35:0] f;
    longint      t;
  } exp_t;

  exp_t sb[3][$];

  addsub_seq #(.WIDTH(32), .CHUNK(8)) u_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a_s[0]), .b(b_s[0]), .sub(sub_s[0]), .sat(sat_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .result(res_s[0]),
    .cout(cout_s[0]), .ovf(ovf_s[0]), .zero(zero_s[0]), .neg(neg_s[0])
  );

  addsub_seq #(.WIDTH(16), .CHUNK(16)) u_p (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a_s[1][15:0]), .b(b_s[1][15:0]), .sub(sub_s[1]), .sat(sat_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .result(res_p),
    .cout(cout_s[1]), .ovf(ovf_s[1]), .zero(zero_s[1]), .neg(neg_s[1])
  );

  addsub_seq #(.WIDTH(16), .CHUNK(4)) u_q (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .a(a_s[2][15:0]), .b(b_s[2][15:0]), .sub(sub_s[2]), .sat(sat_s[2]),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .result(res_q),
    .cout(cout_s[2]), .ovf(ovf_s[2]), .zero(zero_s[2]), .neg(neg_s[2])
  );

  function automatic int wid(input int i);
    return (i == 0) ? 32 : 16;
  endfunction

  function automatic int lat(input int i);
    return (i == 1) ? 1 : 4;
  endfunction

  // Exact signed/unsigned arithmetic on 64-bit integers, then range checks.
  function automatic logic [35:0] ref_model(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input bit sub,
                                            input bit sat);
    longint mask, half, ua, ub, sa, sbv, exact, raw, r;
    bit c, o;
    mask  = (longint'(1) << w) - 1;
    half  = longint'(1) << (w - 1);
    ua    = longint'(a) & mask;
    ub    = longint'(b) & mask;
    sa    = (ua >= half) ? ua - 2 * half : ua;
    sbv   = (ub >= half) ? ub - 2 * half : ub;
    exact = sub ? sa - sbv : sa + sbv;
    if (sub) begin
      c   = (ua >= ub);
      raw = (ua - ub) & mask;
    end else begin
      c   = ((ua + ub) >> w) != 0;
      raw = (ua + ub) & mask;
    end
    o = (exact > half - 1) || (exact < -half);
    r = raw;
    if (sat && o) r = (exact > 0) ? (half - 1) : ((-half) & mask);
    return {32'(r), c, o, (r == 0), 1'((r >> (w - 1)) & 1)};
  endfunction

  function automatic logic [31:0] rand_operand(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return m;
      2:       return 32'h1 << (w - 1);
      3:       return (32'h1 << (w - 1)) - 32'h1;
      default: return $urandom & m;
    endcase
  endfunction

  task automatic check_output(input string name, input int g, input logic [63:0] act,
                              input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s inst%0d: got %h, expected %h", name, g, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int i, input logic [31:0] a, input logic [31:0] b,
                                input bit sub, input bit sat);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    a_s[i] = a;
    b_s[i] = b;
    sub_s[i] = sub;
    sat_s[i] = sat;
    in_valid_s[i] = 1'b1;
    while (!in_ready_s[i] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_output("accept", i, {63'h0, in_ready_s[i]}, 64'h1);
    if (!in_ready_s[i]) begin
      in_valid_s[i] = 1'b0;
      return;
    end
    @(posedge clk);
    e.f = ref_model(wid(i), a, b, sub, sat);
    e.t = longint'($time);
    sb[i].push_back(e);
    #1;
    in_valid_s[i] = 1'b0;
    a_s[i] = $urandom;
    b_s[i] = $urandom;
    sub_s[i] = 1'($urandom_range(0, 1));
    sat_s[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain(input int i);
    int guard;
    guard = 0;
    while (sb[i].size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check_output("drain", i, 64'(sb[i].size()), 64'h0);
  endtask

  task automatic check_reset_outputs(input int i);
    check_output("reset_outputs", i,
                 {27'h0, res_s[i], cout_s[i], ovf_s[i], zero_s[i], neg_s[i], out_valid_s[i]},
                 64'h0);
    check_output("reset_in_ready", i, {63'h0, in_ready_s[i]}, 64'h1);
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      case (rdy_mode[i])
        0:       out_ready_s[i] = 1'b1;
        1:       out_ready_s[i] = ($urandom_range(0, 3) != 0);
        default: out_ready_s[i] = 1'b0;
      endcase
    end
  end

  // Monitors compare the head of the queue every cycle the result is offered, popping on handshake.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    logic ov_prev = 1'b0;
    exp_t e;
    always @(negedge clk) begin
      if (!rst_n) begin
        ov_prev = 1'b0;
      end else begin
        if (out_valid_s[g]) begin
          if (sb[g].size() == 0) begin
            check_output("unexpected_out_valid", g, 64'h1, 64'h0);
          end else begin
            e = sb[g][0];
            check_output("result_flags", g,
                         {28'h0, res_s[g], cout_s[g], ovf_s[g], zero_s[g], neg_s[g]},
                         {28'h0, e.f});
            check_output("in_ready_busy", g, {63'h0, in_ready_s[g]}, 64'h0);
            if (!ov_prev) begin
              check_output("latency", g, 64'((longint'($time) - e.t - P/2) / P), 64'(lat(g)));
            end
            if (out_ready_s[g]) void'(sb[g].pop_front());
          end
        end
        ov_prev = out_valid_s[g];
      end
    end
  end

  initial begin
    #(P * 150000);
    $display("[TB] FAIL watchdog: simulation did not complete, %0d miscompares so far", n_bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_s[i]  = 1'b0;
      a_s[i]         = '0;
      b_s[i]         = '0;
      sub_s[i]       = 1'b0;
      sat_s[i]       = 1'b0;
      out_ready_s[i] = 1'b1;
      rdy_mode[i]    = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_reset_outputs(i);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed 32-bit operations");
    apply_stimulus(0, 32'd5, 32'd3, 1'b1, 1'b0);
    wait_drain(0);
    apply_stimulus(0, 32'd3, 32'd5, 1'b1, 1'b0);
    wait_drain(0);
    apply_stimulus(0, 32'h1234, 32'h1234, 1'b1, 1'b0);
    wait_drain(0);
    apply_stimulus(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    wait_drain(0);
    apply_stimulus(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
    wait_drain(0);
    apply_stimulus(0, 32'h0, 32'h8000_0000, 1'b1, 1'b1);
    wait_drain(0);
    apply_stimulus(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    wait_drain(0);

    $display("[TB] output stall with out_ready low");
    rdy_mode[0] = 2;
    apply_stimulus(0, 32'h8000_0000, 32'h1, 1'b1, 1'b1);
    guard = 0;
    while (!out_valid_s[0] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_output("stall_out_valid", 0, {63'h0, out_valid_s[0]}, 64'h1);
    repeat (5) @(negedge clk);
    rdy_mode[0] = 0;
    wait_drain(0);

    $display("[TB] reset during RUN");
    apply_stimulus(0, 32'h1234_5678, 32'h1, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb[0].delete();
    #1;
    check_reset_outputs(0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    wait_drain(0);

    $display("[TB] random 32/8 operations");
    rdy_mode[0] = 1;
    repeat (200) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      apply_stimulus(0, rand_operand(32), rand_operand(32), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
    end
    wait_drain(0);

    $display("[TB] random 16/16 and 16/4 operations");
    fork
      begin
        rdy_mode[1] = 1;
        repeat (1000) begin
          apply_stimulus(1, rand_operand(16), rand_operand(16), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
        end
        wait_drain(1);
      end
      begin
        rdy_mode[2] = 1;
        repeat (1000) begin
          apply_stimulus(2, rand_operand(16), rand_operand(16), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
        end
        wait_drain(2);
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
